mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single-port unified memory that the multicycle datapath uses for both instruction fetch and data access. Two requesters share the port: the CPU control path (priority) and a DMA/loader port. Each requester uses a req/ack handshake. A fixed-latency synchronous memory sits behind the block, and a starvation counter guarantees that DMA makes progress.

Parameters:
DW, 32, data width
AW, 8, address width (word address)
MEM_LAT, 2, cycles from mem_en to valid mem_rdata; legal range >=1
STARVE_MAX, 3, consecutive CPU grants while DMA is waiting before DMA is forced; legal range >=1

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU request; held high until cpu_ack
cpu_we  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DW  registered read data, valid in the cpu_ack cycle, held afterwards
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the cpu_* ports, for the DMA side
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high when state != IDLE
owner  out  1  0=CPU, 1=DMA; meaningful only when busy

Behaviour:
- Reset values: state IDLE; mem_en, mem_we, cpu_ack, dma_ack, busy = 0; owner = 0; mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0; starve_cnt = 0; wait counter = 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Any req high: choose a winner, latch its we/addr/wdata into the issue registers, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we/addr/wdata come from the latched values.
  - Write: go to DONE.
  - Read: load the wait counter with MEM_LAT and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter reaches 1, capture mem_rdata into the owner's rdata register and go to DONE.
  - Read occupancy is exactly MEM_LAT cycles.
- DONE (1 cycle):
  - Pulse the owner's ack; the other ack stays 0.
  - Go to IDLE unconditionally. The req still high in this cycle is ignored.
- Latency from the IDLE cycle that samples req to ack:
  - Read: MEM_LAT+2 cycles.
  - Write: 2 cycles.
  - Back-to-back transactions cost one extra IDLE cycle each.
- mem_en is high only in ISSUE. mem_we is 0 outside ISSUE. mem_addr/wdata hold their last value.
- The non-owner rdata register never changes. Writes do not change either rdata register.
- Arbitration when both req are high in IDLE:
  - Winner is CPU, unless starve_cnt == STARVE_MAX, in which case DMA wins.
- starve_cnt update, applied in IDLE:
  - Increment when CPU is granted while dma_req is high.
  - Clear when DMA is granted.
  - Otherwise hold. Saturates at STARVE_MAX.
- Requesters must hold the request fields stable from req rise through ack. Behaviour is undefined if they change.
- Dropping req before ack does not cancel an already-granted transaction; the ack still pulses.
- Reset mid-transaction:
  - Returns to IDLE on the reset edge with no ack.
  - A write already issued may have completed in memory.
  - The requester must reissue.

Decomposition:
- Package mem_arb_pkg:
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3
  - owner constants: OWN_CPU=1'b0, OWN_DMA=1'b1
- Sub-module arb_starve_counter: saturating counter with inputs inc, clr and output at_max.
- The FSM, issue registers and rdata capture stay in the top module.

Test Plan:
- MEM_LAT=2. Reset, then cpu_req=1, cpu_we=0, cpu_addr=0x10 at cycle 0; memory returns 0xDEADBEEF. Expect mem_en=1 with mem_addr=0x10 at cycle 1, cpu_ack=1 at cycle 4 with cpu_rdata=0xDEADBEEF, and dma_ack=0 throughout.
- CPU write of addr 0x20, data 0x12345678. Expect mem_en=mem_we=1 for exactly one cycle (cycle 1), cpu_ack at cycle 2, and both rdata registers unchanged.
- cpu_req and dma_req rise together, starve_cnt=0. Expect the CPU transaction first, then the DMA transaction; owner=0 then owner=1.
- STARVE_MAX=3, cpu_req and dma_req held continuously, all reads. Expect mem_en owner sequence CPU, CPU, CPU, DMA, CPU, CPU, CPU, DMA.
- Assert reset in the first WAIT cycle of a DMA read. Expect no dma_ack, busy=0 and mem_en=0 after the edge, and starve_cnt=0.
- MEM_LAT=1, DMA reads of addr 0x01 then 0x02 back-to-back. Expect dma_ack 3 cycles after each IDLE sample, dma_rdata matching each mem_rdata, and cpu_rdata unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified-memory port arbiter.
package mem_arb_pkg;

    // Sequencer states
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Transaction owner
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side req/ack bundle: one instance per requester (CPU, DMA).
interface mem_port_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/arb_starve_counter.sv
// Saturating count of CPU grants won while DMA was waiting.
module arb_starve_counter #(
    parameter int unsigned MAX = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);
    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q;

    assign at_max = (cnt_q == W'(MAX));

    // Clear has priority; increment stops at MAX
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (inc && !at_max) begin
            cnt_q <= cnt_q + W'(1);
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a fixed-latency single-port memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 8,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave cpu,
    mem_port_arbiter_if.slave dma,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int unsigned LW = $clog2(MEM_LAT + 1);

    logic [1:0]    state_q, state_d;
    logic          owner_q, we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
    logic [LW-1:0] cnt_q;
    logic          in_idle, any_req, grant_dma, at_max;

    assign in_idle   = (state_q == IDLE);
    assign any_req   = cpu.req || dma.req;
    // CPU has priority unless DMA has been passed over STARVE_MAX times
    assign grant_dma = dma.req && (!cpu.req || at_max);

    arb_starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clock  (clock),
        .reset  (reset),
        .inc    (in_idle && cpu.req && dma.req && !grant_dma),
        .clr    (in_idle && grant_dma),
        .at_max (at_max)
    );

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ISSUE;
            ISSUE:   state_d = we_q ? DONE : WAIT;
            WAIT:    if (cnt_q == LW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Latch the winner's request fields at grant; they drive the memory bus
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (in_idle && any_req) begin
            owner_q <= grant_dma ? OWN_DMA : OWN_CPU;
            we_q    <= grant_dma ? dma.we    : cpu.we;
            addr_q  <= grant_dma ? dma.addr  : cpu.addr;
            wdata_q <= grant_dma ? dma.wdata : cpu.wdata;
        end
    end

    // Read latency counter: loaded on issue, counts down through WAIT
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_q == ISSUE && !we_q) begin
            cnt_q <= LW'(MEM_LAT);
        end else if (state_q == WAIT) begin
            cnt_q <= cnt_q - LW'(1);
        end
    end

    // Capture read data into the owner's register on the last WAIT cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else if (state_q == WAIT && cnt_q == LW'(1)) begin
            if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
            else                    cpu_rdata_q <= mem_rdata;
        end
    end

    assign mem_en    = (state_q == ISSUE);
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = !in_idle;
    assign owner     = owner_q;
    assign cpu.ack   = (state_q == DONE) && (owner_q == OWN_CPU);
    assign dma.ack   = (state_q == DONE) && (owner_q == OWN_DMA);
    assign cpu.rdata = cpu_rdata_q;
    assign dma.rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: dut0 with MEM_LAT=2, dut1 with MEM_LAT=1, each with its own memory model.
module tb_mem_port_arbiter;

    typedef struct {
        int          dut;
        logic        own;
        logic [31:0] cpu_rd;
        logic [31:0] dma_rd;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        int          dut;
        logic        own;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          cyc;
    } iss_exp_t;

    logic clock = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    ack_exp_t    ack_q[$];
    iss_exp_t    iss_q[$];
    logic [31:0] sh_rd[2][2];
    bit   [1:0]  hold_cpu, hold_dma;

    mem_port_arbiter_if #(.DW(32), .AW(8)) cpu0 ();
    mem_port_arbiter_if #(.DW(32), .AW(8)) dma0 ();
    mem_port_arbiter_if #(.DW(32), .AW(8)) cpu1 ();
    mem_port_arbiter_if #(.DW(32), .AW(8)) dma1 ();

    logic [1:0]  men, mwe, mown, mbusy, ack_cpu, ack_dma;
    logic [7:0]  maddr[2];
    logic [31:0] mwdata[2], mrdata[2], rd_cpu[2], rd_dma[2];

    mem_port_arbiter #(.DW(32), .AW(8), .MEM_LAT(2), .STARVE_MAX(3)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .cpu       (cpu0),
        .dma       (dma0),
        .mem_en    (men[0]),
        .mem_we    (mwe[0]),
        .mem_addr  (maddr[0]),
        .mem_wdata (mwdata[0]),
        .mem_rdata (mrdata[0]),
        .busy      (mbusy[0]),
        .owner     (mown[0])
    );

    mem_port_arbiter #(.DW(32), .AW(8), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .cpu       (cpu1),
        .dma       (dma1),
        .mem_en    (men[1]),
        .mem_we    (mwe[1]),
        .mem_addr  (maddr[1]),
        .mem_wdata (mwdata[1]),
        .mem_rdata (mrdata[1]),
        .busy      (mbusy[1]),
        .owner     (mown[1])
    );

    assign ack_cpu[0] = cpu0.ack;
    assign ack_dma[0] = dma0.ack;
    assign ack_cpu[1] = cpu1.ack;
    assign ack_dma[1] = dma1.ack;
    assign rd_cpu[0]  = cpu0.rdata;
    assign rd_dma[0]  = dma0.rdata;
    assign rd_cpu[1]  = cpu1.rdata;
    assign rd_dma[1]  = dma1.rdata;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    // Memory models: written words override the init pattern; L register stages of read data
    logic [31:0] wmem0[256], wmem1[256];
    bit          wr0[256], wr1[256];
    logic [31:0] p0a = '0, p0b = '0, p1a = '0;
    assign mrdata[0] = p0b;
    assign mrdata[1] = p1a;

    always @(posedge clock) begin
        p0b <= p0a;
        p0a <= wr0[maddr[0]] ? wmem0[maddr[0]] : init_word(maddr[0]);
        p1a <= wr1[maddr[1]] ? wmem1[maddr[1]] : init_word(maddr[1]);
        if (men[0] && mwe[0]) begin
            wmem0[maddr[0]] = mwdata[0];
            wr0[maddr[0]]   = 1'b1;
        end
        if (men[1] && mwe[1]) begin
            wmem1[maddr[1]] = mwdata[1];
            wr1[maddr[1]]   = 1'b1;
        end
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    task automatic push_issue(int d, logic own, logic we, logic [7:0] a, logic [31:0] wd, int c);
        iss_exp_t e;
        e.dut = d; e.own = own; e.we = we; e.addr = a; e.wdata = wd; e.cyc = c;
        iss_q.push_back(e);
    endtask

    task automatic push_ack(int d, logic own, bit is_read, logic [31:0] data, int c);
        ack_exp_t e;
        if (is_read) sh_rd[d][own] = data;
        e.dut = d; e.own = own; e.cpu_rd = sh_rd[d][0]; e.dma_rd = sh_rd[d][1]; e.cyc = c;
        ack_q.push_back(e);
    endtask

    task automatic drive(int d, bit side, logic we, logic [7:0] a, logic [31:0] wd);
        if (d == 0 && !side) begin cpu0.req = 1; cpu0.we = we; cpu0.addr = a; cpu0.wdata = wd; end
        if (d == 0 &&  side) begin dma0.req = 1; dma0.we = we; dma0.addr = a; dma0.wdata = wd; end
        if (d == 1 && !side) begin cpu1.req = 1; cpu1.we = we; cpu1.addr = a; cpu1.wdata = wd; end
        if (d == 1 &&  side) begin dma1.req = 1; dma1.we = we; dma1.addr = a; dma1.wdata = wd; end
    endtask

    // One cycle; requesters not marked as holding drop req once acked
    task automatic step();
        @(negedge clock);
        if (cpu0.ack && !hold_cpu[0]) cpu0.req = 0;
        if (dma0.ack && !hold_dma[0]) dma0.req = 0;
        if (cpu1.ack && !hold_cpu[1]) cpu1.req = 0;
        if (dma1.ack && !hold_dma[1]) dma1.req = 0;
    endtask

    task automatic wait_ack(int d, bit side, int budget);
        logic seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = side ? ack_dma[d] : ack_cpu[d];
        end
        chk("ack within budget", 32'(seen), 32'd1);
    endtask

    // Monitor: pops expected issues/acks whenever the DUT presents them
    iss_exp_t ie;
    ack_exp_t ae;
    always @(negedge clock) begin
        for (int d = 0; d < 2; d++) begin
            if (mwe[d] && !men[d]) begin
                checks++;
                $display("FAIL mem_we without mem_en: dut%0d cycle %0d", d, cyc);
            end
            if (men[d]) begin
                if (iss_q.size() == 0 || iss_q[0].dut != d) begin
                    checks++;
                    $display("FAIL unexpected mem_en: dut%0d addr %h cycle %0d", d, maddr[d], cyc);
                end else begin
                    ie = iss_q.pop_front();
                    chk("issue cycle", 32'(cyc), 32'(ie.cyc));
                    chk("issue owner", 32'(mown[d]), 32'(ie.own));
                    chk("issue we", 32'(mwe[d]), 32'(ie.we));
                    chk("issue addr", 32'(maddr[d]), 32'(ie.addr));
                    chk("issue busy", 32'(mbusy[d]), 32'd1);
                    if (ie.we) chk("issue wdata", mwdata[d], ie.wdata);
                end
            end
            if (ack_cpu[d] || ack_dma[d]) begin
                if (ack_q.size() == 0 || ack_q[0].dut != d) begin
                    checks++;
                    $display("FAIL unexpected ack: dut%0d cpu %b dma %b cycle %0d",
                             d, ack_cpu[d], ack_dma[d], cyc);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack cycle", 32'(cyc), 32'(ae.cyc));
                    chk("ack side dma", 32'(ack_dma[d]), 32'(ae.own));
                    chk("ack side cpu", 32'(ack_cpu[d]), 32'(!ae.own));
                    chk("cpu rdata", rd_cpu[d], ae.cpu_rd);
                    chk("dma rdata", rd_dma[d], ae.dma_rd);
                end
            end
        end
    end

    int t0;
    int n;

    initial begin
        reset = 1'b1;
        hold_cpu = '0;
        hold_dma = '0;
        for (int d = 0; d < 2; d++) begin sh_rd[d][0] = '0; sh_rd[d][1] = '0; end
        cpu0.req = 0; cpu0.we = 0; cpu0.addr = '0; cpu0.wdata = '0;
        dma0.req = 0; dma0.we = 0; dma0.addr = '0; dma0.wdata = '0;
        cpu1.req = 0; cpu1.we = 0; cpu1.addr = '0; cpu1.wdata = '0;
        dma1.req = 0; dma1.we = 0; dma1.addr = '0; dma1.wdata = '0;
        step();
        step();

        // Reset state
        chk("rst mem_en", 32'(men[0]), 32'd0);
        chk("rst mem_we", 32'(mwe[0]), 32'd0);
        chk("rst busy", 32'(mbusy[0]), 32'd0);
        chk("rst owner", 32'(mown[0]), 32'd0);
        chk("rst mem_addr", 32'(maddr[0]), 32'd0);
        chk("rst mem_wdata", mwdata[0], 32'd0);
        chk("rst cpu_rdata", rd_cpu[0], 32'd0);
        chk("rst dma_rdata", rd_dma[0], 32'd0);
        chk("rst cpu_ack", 32'(ack_cpu[0]), 32'd0);
        chk("rst dma_ack", 32'(ack_dma[0]), 32'd0);
        chk("rst starve_cnt", 32'(dut0.u_starve.cnt_q), 32'd0);
        reset = 1'b0;
        step();

        // CPU read 0x10, ack at MEM_LAT+2
        t0 = cyc;
        drive(0, 0, 1'b0, 8'h10, 32'h0);
        push_issue(0, 1'b0, 1'b0, 8'h10, 32'h0, t0 + 1);
        push_ack(0, 1'b0, 1, 32'hDEADBEEF, t0 + 4);
        wait_ack(0, 0, 20);

        // CPU write 0x20, ack at 2, rdata registers unchanged
        step();
        t0 = cyc;
        drive(0, 0, 1'b1, 8'h20, 32'h12345678);
        push_issue(0, 1'b0, 1'b1, 8'h20, 32'h12345678, t0 + 1);
        push_ack(0, 1'b0, 0, 32'h0, t0 + 2);
        wait_ack(0, 0, 20);

        // DMA read back the written word
        step();
        t0 = cyc;
        drive(0, 1, 1'b0, 8'h20, 32'h0);
        push_issue(0, 1'b1, 1'b0, 8'h20, 32'h0, t0 + 1);
        push_ack(0, 1'b1, 1, 32'h12345678, t0 + 4);
        wait_ack(0, 1, 20);

        // Simultaneous requests: CPU first, DMA after one IDLE cycle
        step();
        t0 = cyc;
        drive(0, 0, 1'b0, 8'h30, 32'h0);
        drive(0, 1, 1'b0, 8'h40, 32'h0);
        push_issue(0, 1'b0, 1'b0, 8'h30, 32'h0, t0 + 1);
        push_ack(0, 1'b0, 1, 32'hC0FFEE30, t0 + 4);
        push_issue(0, 1'b1, 1'b0, 8'h40, 32'h0, t0 + 6);
        push_ack(0, 1'b1, 1, 32'hC0FFEE40, t0 + 9);
        wait_ack(0, 1, 30);

        // Both held: CPU,CPU,CPU,DMA repeating
        step();
        t0 = cyc;
        hold_cpu[0] = 1;
        hold_dma[0] = 1;
        drive(0, 0, 1'b0, 8'h30, 32'h0);
        drive(0, 1, 1'b0, 8'h41, 32'h0);
        for (int k = 0; k < 8; k++) begin
            logic own;
            own = ((k % 4) == 3);
            push_issue(0, own, 1'b0, own ? 8'h41 : 8'h30, 32'h0, t0 + 5 * k + 1);
            push_ack(0, own, 1, own ? 32'hC0FFEE41 : 32'hC0FFEE30, t0 + 5 * k + 4);
        end
        n = 0;
        for (int i = 0; i < 60 && n < 8; i++) begin
            step();
            if (ack_cpu[0] || ack_dma[0]) n++;
        end
        chk("starve acks seen", 32'(n), 32'd8);
        hold_cpu[0] = 0;
        hold_dma[0] = 0;
        cpu0.req = 0;
        dma0.req = 0;

        // Reset in first WAIT cycle of a DMA read: no ack, back to IDLE
        step();
        t0 = cyc;
        drive(0, 1, 1'b0, 8'h42, 32'h0);
        push_issue(0, 1'b1, 1'b0, 8'h42, 32'h0, t0 + 1);
        step();
        step();
        reset = 1'b1;
        dma0.req = 0;
        for (int d = 0; d < 2; d++) begin sh_rd[d][0] = '0; sh_rd[d][1] = '0; end
        step();
        chk("mid-rst busy", 32'(mbusy[0]), 32'd0);
        chk("mid-rst mem_en", 32'(men[0]), 32'd0);
        chk("mid-rst dma_ack", 32'(ack_dma[0]), 32'd0);
        chk("mid-rst starve_cnt", 32'(dut0.u_starve.cnt_q), 32'd0);
        chk("mid-rst cpu_rdata", rd_cpu[0], 32'd0);
        reset = 1'b0;
        repeat (6) step();

        // MEM_LAT=1: CPU read, then two back-to-back DMA reads
        t0 = cyc;
        drive(1, 0, 1'b0, 8'h05, 32'h0);
        push_issue(1, 1'b0, 1'b0, 8'h05, 32'h0, t0 + 1);
        push_ack(1, 1'b0, 1, 32'hC0FFEE05, t0 + 3);
        wait_ack(1, 0, 10);
        step();
        t0 = cyc;
        hold_dma[1] = 1;
        drive(1, 1, 1'b0, 8'h01, 32'h0);
        push_issue(1, 1'b1, 1'b0, 8'h01, 32'h0, t0 + 1);
        push_ack(1, 1'b1, 1, 32'hC0FFEE01, t0 + 3);
        push_issue(1, 1'b1, 1'b0, 8'h02, 32'h0, t0 + 5);
        push_ack(1, 1'b1, 1, 32'hC0FFEE02, t0 + 7);
        wait_ack(1, 1, 10);
        dma1.addr = 8'h02;
        wait_ack(1, 1, 10);
        hold_dma[1] = 0;
        dma1.req = 0;

        repeat (5) step();
        chk("ack queue drained", 32'(ack_q.size()), 32'd0);
        chk("issue queue drained", 32'(iss_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
